// File: rtl/montgomery_pkg.sv
// Shared types and default widths for the Montgomery exponentiation unit.
// The precompute stage's optional m-cache is enabled with MONT_PRECOMP_CACHE_EN.
package montgomery_pkg;

  localparam int WORD_WIDTH_DEF = 32;
  localparam int T_WIDTH_DEF    = 5;

  typedef enum logic [1:0] {
    PC_IDLE   = 2'd0,
    PC_CHECK  = 2'd1,
    PC_REDUCE = 2'd2,
    PC_DONE   = 2'd3
  } precomp_state_e;

  typedef enum logic [2:0] {
    EXP_IDLE     = 3'd0,
    EXP_INIT     = 3'd1,
    EXP_SQUARE   = 3'd2,
    EXP_MULTIPLY = 3'd3,
    EXP_DONE     = 3'd4
  } exp_state_e;

endpackage

// File: rtl/montgomery_precompute_msb_index.sv
// Combinational priority encoder: index of the highest set bit, 0 for a zero input.
module msb_index #(
  parameter int WORD_WIDTH = 32,
  parameter int T_WIDTH    = 5
) (
  input  logic [WORD_WIDTH-1:0] value,
  output logic [T_WIDTH-1:0]    index
);

  logic [T_WIDTH-1:0] index_s;

  // Later (higher) set bits override earlier ones.
  always_comb begin
    index_s = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      index_s = value[i] ? T_WIDTH'(i) : index_s;
    end
  end

  assign index = index_s;

endmodule

// File: rtl/montgomery_precompute.sv
// Sequential precompute of R mod m, R^2 mod m and msb(e) by shift-and-subtract.
// Define MONT_PRECOMP_CACHE_EN to skip the reduction when m repeats.
module montgomery_precompute
  import montgomery_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int T_WIDTH    = T_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WORD_WIDTH-1:0] m,
  input  logic [WORD_WIDTH-1:0] e,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WORD_WIDTH-1:0] r_mod_m,
  output logic [WORD_WIDTH-1:0] r2_mod_m,
  output logic [T_WIDTH-1:0]    t
);

  localparam int K_WIDTH = $clog2(2 * WORD_WIDTH + 1);
  localparam logic [K_WIDTH-1:0]    K_ONE  = {{(K_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [K_WIDTH-1:0]    K_HALF = K_WIDTH'(WORD_WIDTH);
  localparam logic [K_WIDTH-1:0]    K_LAST = K_WIDTH'(2 * WORD_WIDTH);
  localparam logic [WORD_WIDTH-1:0] R_ONE  = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WORD_WIDTH-1:0] M_MIN  = {{(WORD_WIDTH-2){1'b0}}, 2'b11};

  precomp_state_e        state_r, state_s;
  logic [WORD_WIDTH-1:0] m_lat_r, e_lat_r;
  logic [WORD_WIDTH-1:0] r_r, rm_r, r_next_s;
  logic [WORD_WIDTH:0]   r_dbl_s;
  logic [K_WIDTH-1:0]    k_r, k_inc_s;
  logic                  err_pend_r, m_invalid_s, cache_hit_s;
  logic                  latch_s, init_s, step_s, finish_s;
  logic                  busy_r, done_r, error_r;
  logic [WORD_WIDTH-1:0] r_mod_m_r, r2_mod_m_r;
  logic [T_WIDTH-1:0]    t_r, t_s;

  msb_index #(.WORD_WIDTH(WORD_WIDTH), .T_WIDTH(T_WIDTH)) u_msb (
    .value (e_lat_r),
    .index (t_s)
  );

  assign m_invalid_s = ~m_lat_r[0] | (m_lat_r < M_MIN);
  assign k_inc_s     = k_r + K_ONE;
  // r < m always holds, so doubling fits in one extra bit and one subtract suffices.
  assign r_dbl_s     = {r_r, 1'b0};
  assign r_next_s    = WORD_WIDTH'((r_dbl_s >= {1'b0, m_lat_r}) ? (r_dbl_s - {1'b0, m_lat_r}) : r_dbl_s);

`ifdef MONT_PRECOMP_CACHE_EN
  logic                  cache_valid_r, hit_pend_r;
  logic [WORD_WIDTH-1:0] cache_m_r;
  assign cache_hit_s = cache_valid_r & (cache_m_r == m_lat_r);
`else
  assign cache_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= PC_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      PC_IDLE:   state_s = enable ? PC_CHECK : PC_IDLE;
      PC_CHECK:  state_s = (m_invalid_s | cache_hit_s) ? PC_DONE : PC_REDUCE;
      PC_REDUCE: state_s = (k_inc_s == K_LAST) ? PC_DONE : PC_REDUCE;
      PC_DONE:   state_s = PC_IDLE;
      default:   state_s = PC_IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    latch_s  = 1'b0;
    init_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      PC_IDLE:   latch_s  = enable;
      PC_CHECK:  init_s   = 1'b1;
      PC_REDUCE: step_s   = 1'b1;
      PC_DONE:   finish_s = 1'b1;
      default:   latch_s  = 1'b0;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_lat_r    <= '0;
      e_lat_r    <= '0;
      r_r        <= '0;
      rm_r       <= '0;
      k_r        <= '0;
      err_pend_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      r_mod_m_r  <= '0;
      r2_mod_m_r <= '0;
      t_r        <= '0;
`ifdef MONT_PRECOMP_CACHE_EN
      cache_valid_r <= 1'b0;
      cache_m_r     <= '0;
      hit_pend_r    <= 1'b0;
`endif
    end else begin
      busy_r <= (state_s != PC_IDLE);
      done_r <= finish_s;
      if (latch_s) begin
        m_lat_r <= m;
        e_lat_r <= e;
      end
      if (init_s) begin
        r_r        <= R_ONE;
        k_r        <= '0;
        err_pend_r <= m_invalid_s;
`ifdef MONT_PRECOMP_CACHE_EN
        hit_pend_r <= cache_hit_s & ~m_invalid_s;
`endif
      end
      if (step_s) begin
        r_r <= r_next_s;
        k_r <= k_inc_s;
        if (k_inc_s == K_HALF) begin
          rm_r <= r_next_s;
        end
      end
      if (finish_s) begin
        t_r <= t_s;
        if (err_pend_r) begin
          error_r    <= 1'b1;
          r_mod_m_r  <= '0;
          r2_mod_m_r <= '0;
`ifdef MONT_PRECOMP_CACHE_EN
          cache_valid_r <= 1'b0;
        end else if (hit_pend_r) begin
          error_r <= 1'b0;
`endif
        end else begin
          error_r    <= 1'b0;
          r_mod_m_r  <= rm_r;
          r2_mod_m_r <= r_r;
`ifdef MONT_PRECOMP_CACHE_EN
          cache_valid_r <= 1'b1;
          cache_m_r     <= m_lat_r;
`endif
        end
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign r_mod_m  = r_mod_m_r;
  assign r2_mod_m = r2_mod_m_r;
  assign t        = t_r;

endmodule

// File: tb/tb_montgomery_precompute.sv
// Self-checking bench for montgomery_precompute; follows MONT_PRECOMP_CACHE_EN when defined.
module tb_montgomery_precompute;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [W-1:0]  m, e;
  logic          busy, done, error;
  logic [W-1:0]  r_mod_m, r2_mod_m;
  logic [TW-1:0] t;

  montgomery_precompute #(.WORD_WIDTH(W), .T_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .m(m), .e(e),
    .busy(busy), .done(done), .error(error),
    .r_mod_m(r_mod_m), .r2_mod_m(r2_mod_m), .t(t)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0]  exp_rm = '0, exp_r2 = '0, mc_m = '0;
  logic [TW-1:0] exp_t = '0;
  logic          exp_error = 1'b0, mc_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [TW-1:0] ref_msb(input logic [W-1:0] v);
    logic [W-1:0] x = v;
    int n = 0;
    while (x > 1) begin
      x = x >> 1;
      n++;
    end
    return TW'(n);
  endfunction

  // Reference: R mod m and R^2 mod m straight from wide modular arithmetic.
  task automatic model_job(input logic [W-1:0] mm, input logic [W-1:0] ee, output int lat);
    logic [127:0] big;
    exp_t = ref_msb(ee);
    if (!mm[0] || mm < 3) begin
      exp_error = 1'b1; exp_rm = '0; exp_r2 = '0; mc_valid = 1'b0; lat = 2;
    end else begin
      exp_error = 1'b0;
`ifdef MONT_PRECOMP_CACHE_EN
      if (mc_valid && mc_m == mm) begin
        lat = 2;
        return;
      end
`endif
      big = (128'd1 << W) % {96'd0, mm};
      exp_rm = big[W-1:0];
      big = (128'd1 << (2 * W)) % {96'd0, mm};
      exp_r2 = big[W-1:0];
      mc_valid = 1'b1; mc_m = mm; lat = 2 * W + 2;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".error"}, {63'd0, error}, {63'd0, exp_error});
    chk({tag, ".r_mod_m"}, {32'd0, r_mod_m}, {32'd0, exp_rm});
    chk({tag, ".r2_mod_m"}, {32'd0, r2_mod_m}, {32'd0, exp_r2});
    chk({tag, ".t"}, {59'd0, t}, {59'd0, exp_t});
  endtask

  task automatic start_job(input logic [W-1:0] mm, input logic [W-1:0] ee);
    @(negedge clk);
    m = mm; e = ee; enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0; m = $urandom; e = $urandom;
  endtask

  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
    end
  endtask

  task automatic run_job(input string tag, input logic [W-1:0] mm, input logic [W-1:0] ee);
    int lat_exp, lat, busy_cnt;
    model_job(mm, ee, lat_exp);
    start_job(mm, ee);
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) break;
      busy_cnt += busy ? 1 : 0;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(lat_exp));
    chk({tag, ".busy_at_done"}, {63'd0, busy}, 64'd0);
    check_outputs(tag);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
    check_outputs({tag, ".hold"});
  endtask

  initial begin
    int lat_exp, lat, gap;
    logic [W-1:0] last_m, mm, ee;
    reset = 1'b1; enable = 1'b0; m = '0; e = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    check_outputs("reset");
    reset = 1'b0;

    run_job("m3233_e17", 32'd3233, 32'd17);
    run_job("m3233_e65537", 32'd3233, 32'd65537);
    run_job("m7_e1", 32'd7, 32'd1);
    chk("m7.const_rm", {32'd0, r_mod_m}, 64'd4);
    chk("m7.const_r2", {32'd0, r2_mod_m}, 64'd2);
    run_job("m7_e0", 32'd7, 32'd0);
    run_job("m3234_even", 32'd3234, 32'd1000);
    run_job("m0", 32'd0, 32'hFFFF_FFFF);
    run_job("m3233_after_err", 32'd3233, 32'd17);

    // Abort mid-job with reset.
    start_job(32'd3233, 32'd17);
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_rm = '0; exp_r2 = '0; exp_t = '0; exp_error = 1'b0; mc_valid = 1'b0;
    chk("midreset.busy", {63'd0, busy}, 64'd0);
    chk("midreset.done", {63'd0, done}, 64'd0);
    check_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    run_job("after_reset_m7", 32'd7, 32'd9);

    // Enable re-pulsed while busy is ignored.
    model_job(32'd3233, 32'd17, lat_exp);
    start_job(32'd3233, 32'd17);
    repeat (9) @(posedge clk);
    @(negedge clk);
    m = 32'd11; enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_done(10, lat);
    chk("repulse.latency", 64'(lat), 64'(lat_exp));
    check_outputs("repulse");
    @(posedge clk);
    #1;
    chk("repulse.idle", {63'd0, busy}, 64'd0);

    // Enable held high: back-to-back jobs.
    model_job(32'd13, 32'd3, lat_exp);
    @(negedge clk);
    m = 32'd13; e = 32'd3; enable = 1'b1;
    @(posedge clk);
    #1;
    m = 32'd11; e = 32'd200;
    wait_done(0, lat);
    chk("b2b.first_latency", 64'(lat), 64'(lat_exp));
    check_outputs("b2b.first");
    model_job(32'd11, 32'd200, lat_exp);
    gap = 0;
    while (gap < 300) begin
      @(posedge clk);
      gap++;
      #1;
      if (done) break;
    end
    enable = 1'b0;
    chk("b2b.spacing", 64'(gap), 64'(lat_exp + 1));
    check_outputs("b2b.second");
    @(posedge clk);
    #1;
    chk("b2b.stops", {63'd0, busy}, 64'd0);

    // Randomized jobs, including invalid and repeated moduli.
    last_m = 32'd11;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 9))
        0:       mm = $urandom & 32'hFFFF_FFFE;
        1:       mm = 32'd1;
        2:       mm = last_m;
        default: mm = $urandom | 32'd1;
      endcase
      ee = $urandom >> $urandom_range(0, 31);
      run_job($sformatf("rand%0d", i), mm, ee);
      if (mm[0] && mm >= 3) last_m = mm;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
